cpu_seq: RTL and testbench
==========================

# cpu_seq

Parametrised instruction-sequencing unit for the one-cycle CPU, replacing the plain program counter. It holds the PC, a base register for base-relative jumps, and a hardware return-address stack for CALL/RET. It also handles conditional jumps, stalls, HALT, and stack-fault detection. `PC_OUT` drives the instruction ROM address; op/target fields come from `cpu_id`.

## Interface
Parameters:
- AWIDTH, 8, width of PC, base register and jump target/offset
- STACK_DEPTH, 4, return-stack entries (≥1)
- SPW, $clog2(STACK_DEPTH+1), stack-pointer width (derived, not overridden)

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  reset, synchronous, active-low
- EN  in  1  advance enable; 0 = stall, all state held
- OP  in  3  sequencer op (encodings below)
- COND  in  1  branch condition from ALU flags
- ADDR  in  AWIDTH  absolute target / base offset / base-register data
- PC_OUT  out  AWIDTH  current instruction address (registered)
- BASE_OUT  out  AWIDTH  base register value
- SP_OUT  out  SPW  stack occupancy, 0..STACK_DEPTH
- HALTED  out  1  high in HALT state
- ERR  out  1  high in FAULT state (stack overflow/underflow)

## Operation
- OP encodings:
  - 0 NEXT: PC+1
  - 1 JMP: PC=ADDR
  - 2 JREL: PC=BASE+ADDR
  - 3 JCOND: PC=ADDR if COND else PC+1
  - 4 CALL: push PC+1, PC=ADDR
  - 5 RET: PC=pop
  - 6 LDB: BASE=ADDR, PC+1
  - 7 HALT
- States: RUN, HALT, FAULT.
  - RUN executes OP when EN=1.
  - HALT and FAULT hold all registers and ignore EN/OP.
  - Both states are left only by reset.
- RUN→HALT on OP=7. PC is not advanced and stays on the HALT instruction.
- RUN→FAULT on CALL with SP=STACK_DEPTH (overflow) or RET with SP=0 (underflow).
  - PC, stack and SP are unchanged.
  - ERR=1.
- Arithmetic is unsigned modulo 2^AWIDTH:
  - PC+1 from all-ones wraps to 0.
  - BASE+ADDR discards the carry.
  - A CALL at PC=all-ones pushes 0.
- The stack is LIFO. Push writes entry[SP] then SP+1; pop reads entry[SP-1] then SP-1. Entries at or above SP are don't-care.
- EN=0 in RUN: no change to any register, including BASE and SP.
- COND is sampled only for JCOND and ignored otherwise.

## Timing
- Reset, applied on an edge with RST=0 and taking priority over EN/OP:
  - PC_OUT=0, BASE_OUT=0, SP_OUT=0
  - HALTED=0, ERR=0, state RUN
  - stack contents undefined
- Latency is one cycle. OP/ADDR/COND sampled at edge N take effect in PC_OUT/BASE_OUT/SP_OUT after edge N. The fetch at the new PC is combinational ROM in the same cycle.
- Reset asserted mid-operation, including during HALT/FAULT, clears everything at that edge. The next PC_OUT is 0.
- HALTED/ERR are registered and assert in the same cycle the PC freezes.
- RET immediately after CALL with EN=1 on both cycles returns the pushed address. No forwarding hazard, since push/pop are sequential.

## Structure
- Shared package `cpu_pkg`:
  - OP encodings as localparams (OP_NEXT…OP_HALT)
  - state encoding (ST_RUN, ST_HALT, ST_FAULT)
  - both reused by `cpu_id`
- Sub-module `cpu_ret_stack`, parametrised by AWIDTH and STACK_DEPTH:
  - inputs PUSH, POP, DIN
  - outputs DOUT, SP, FULL, EMPTY
  - synchronous active-low reset on SP only
- `cpu_seq` holds the FSM, PC and BASE registers and the next-PC mux.

## Test plan
All scenarios use AWIDTH=8, STACK_DEPTH=4.
- Reset then 3 cycles of NEXT, EN=1 → PC_OUT 0,1,2,3. Then EN=0 for 2 cycles → PC_OUT holds 3.
- PC=0xFF, NEXT → PC_OUT=0x00. Then LDB ADDR=0xF0, then JREL ADDR=0x20 → BASE_OUT=0xF0, PC_OUT=0x10.
- JCOND ADDR=0x40, COND=0 → PC+1. JCOND ADDR=0x40, COND=1 → PC_OUT=0x40.
- From PC=0x10: CALL 0x50, then at 0x50 CALL 0x60 → SP_OUT=2. Then RET → PC_OUT=0x51, RET → PC_OUT=0x11, SP_OUT=0.
- Five nested CALLs → after the 5th: ERR=1, SP_OUT=4, PC_OUT frozen. Separately, RET at SP=0 → ERR=1, PC frozen. Reset → ERR=0, PC_OUT=0.
- HALT at PC=0x07 → HALTED=1, PC_OUT=0x07 held for 10 cycles regardless of OP/EN. RST=0 for one edge → HALTED=0, PC_OUT=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU sequencer and decoder.
// Contents: sequencer op encodings and sequencer state encoding.
// No logic; imported by cpu_seq, cpu_ret_stack users and cpu_id.
package cpu_pkg;

    // Sequencer op encodings, as produced by cpu_id.
    localparam logic [2:0] OP_NEXT  = 3'd0;
    localparam logic [2:0] OP_JMP   = 3'd1;
    localparam logic [2:0] OP_JREL  = 3'd2;
    localparam logic [2:0] OP_JCOND = 3'd3;
    localparam logic [2:0] OP_CALL  = 3'd4;
    localparam logic [2:0] OP_RET   = 3'd5;
    localparam logic [2:0] OP_LDB   = 3'd6;
    localparam logic [2:0] OP_HALT  = 3'd7;

    // Sequencer states. HALT and FAULT are only left through reset.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } seq_state_t;

endpackage

// File: rtl/cpu_ret_stack.sv
// Hardware return-address stack (LIFO) for CALL/RET.
// Ports: CLK, RST (sync active-low, clears SP only), PUSH/POP/DIN in;
//        DOUT (top entry, entry[SP-1]), SP occupancy, FULL, EMPTY out.
module cpu_ret_stack #(
    parameter int AWIDTH      = 8,
    parameter int STACK_DEPTH = 4,
    parameter int SPW         = $clog2(STACK_DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              PUSH,
    input  logic              POP,
    input  logic [AWIDTH-1:0] DIN,
    output logic [AWIDTH-1:0] DOUT,
    output logic [SPW-1:0]    SP,
    output logic              FULL,
    output logic              EMPTY
);

    logic [AWIDTH-1:0] mem [STACK_DEPTH];
    logic [SPW-1:0]    sp_q;

    assign SP    = sp_q;
    assign FULL  = (sp_q == SPW'(STACK_DEPTH));
    assign EMPTY = (sp_q == '0);

    // Caller never pushes when FULL or pops when EMPTY.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            sp_q <= '0;
        end else if (PUSH) begin
            sp_q <= sp_q + SPW'(1);
        end else if (POP) begin
            sp_q <= sp_q - SPW'(1);
        end
    end

    // Storage is deliberately not reset; entries at or above SP are don't-care.
    // Index compare loop keeps the write in range when SP equals the depth.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (PUSH && (sp_q == SPW'(i))) begin
                mem[i] <= DIN;
            end
        end
    end

    always_comb begin
        DOUT = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (sp_q == SPW'(i + 1)) begin
                DOUT = mem[i];
            end
        end
    end

endmodule

// File: rtl/cpu_seq.sv
// Instruction sequencer: PC, base register, return stack, RUN/HALT/FAULT FSM.
// Ports: CLK, RST (sync active-low), EN, OP, COND, ADDR in;
//        PC_OUT, BASE_OUT, SP_OUT, HALTED, ERR out (all registered, 1-cycle latency).
module cpu_seq
    import cpu_pkg::*;
#(
    parameter int AWIDTH      = 8,
    parameter int STACK_DEPTH = 4,
    parameter int SPW         = $clog2(STACK_DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic [2:0]        OP,
    input  logic              COND,
    input  logic [AWIDTH-1:0] ADDR,
    output logic [AWIDTH-1:0] PC_OUT,
    output logic [AWIDTH-1:0] BASE_OUT,
    output logic [SPW-1:0]    SP_OUT,
    output logic              HALTED,
    output logic              ERR
);

    seq_state_t        state_q, state_d;
    logic [AWIDTH-1:0] pc_q, pc_d;
    logic [AWIDTH-1:0] base_q, base_d;
    logic [AWIDTH-1:0] pc_inc;
    logic              push, pop;
    logic [AWIDTH-1:0] stk_dout;
    logic              stk_full, stk_empty;

    // Unsigned modulo arithmetic: all-ones + 1 wraps to 0, so CALL there pushes 0.
    assign pc_inc = pc_q + AWIDTH'(1);

    cpu_ret_stack #(
        .AWIDTH      (AWIDTH),
        .STACK_DEPTH (STACK_DEPTH),
        .SPW         (SPW)
    ) u_stack (
        .CLK   (CLK),
        .RST   (RST),
        .PUSH  (push),
        .POP   (pop),
        .DIN   (pc_inc),
        .DOUT  (stk_dout),
        .SP    (SP_OUT),
        .FULL  (stk_full),
        .EMPTY (stk_empty)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= ST_RUN;
            pc_q    <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            base_q  <= base_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        base_d  = base_q;
        push    = 1'b0;
        pop     = 1'b0;
        // HALT/FAULT fall through with everything held.
        if (state_q == ST_RUN && EN) begin
            case (OP)
                OP_NEXT:  pc_d = pc_inc;
                OP_JMP:   pc_d = ADDR;
                OP_JREL:  pc_d = base_q + ADDR;
                OP_JCOND: pc_d = COND ? ADDR : pc_inc;
                OP_CALL: begin
                    // Overflow faults without touching PC or stack.
                    if (stk_full) begin
                        state_d = ST_FAULT;
                    end else begin
                        push = 1'b1;
                        pc_d = ADDR;
                    end
                end
                OP_RET: begin
                    if (stk_empty) begin
                        state_d = ST_FAULT;
                    end else begin
                        pop  = 1'b1;
                        pc_d = stk_dout;
                    end
                end
                OP_LDB: begin
                    base_d = ADDR;
                    pc_d   = pc_inc;
                end
                OP_HALT:  state_d = ST_HALT;
                default:  ;
            endcase
        end
    end

    assign PC_OUT   = pc_q;
    assign BASE_OUT = base_q;
    assign HALTED   = (state_q == ST_HALT);
    assign ERR      = (state_q == ST_FAULT);

endmodule

// File: tb/tb_cpu_seq.sv
// Testbench for cpu_seq (AWIDTH=8, STACK_DEPTH=4).
// Each step pushes the expected register snapshot and records the observed one;
// each test task pops and compares its own snapshots.
module tb_cpu_seq;
    import cpu_pkg::*;

    typedef struct packed {
        logic [7:0] pc;
        logic [7:0] base;
        logic [2:0] sp;
        logic       halted;
        logic       err;
    } snap_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       EN = 1'b0;
    logic [2:0] OP = 3'd0;
    logic       COND = 1'b0;
    logic [7:0] ADDR = 8'd0;
    logic [7:0] PC_OUT;
    logic [7:0] BASE_OUT;
    logic [2:0] SP_OUT;
    logic       HALTED;
    logic       ERR;

    int errors = 0;
    int checks = 0;

    snap_t exp_q[$];
    snap_t obs_q[$];

    cpu_seq #(.AWIDTH(8), .STACK_DEPTH(4)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .EN       (EN),
        .OP       (OP),
        .COND     (COND),
        .ADDR     (ADDR),
        .PC_OUT   (PC_OUT),
        .BASE_OUT (BASE_OUT),
        .SP_OUT   (SP_OUT),
        .HALTED   (HALTED),
        .ERR      (ERR)
    );

    always #5 CLK = ~CLK;

    function automatic snap_t mk(input logic [7:0] pc, input logic [7:0] base,
                                 input logic [2:0] sp, input logic h, input logic e);
        snap_t s;
        s.pc = pc; s.base = base; s.sp = sp; s.halted = h; s.err = e;
        return s;
    endfunction

    // Drive one cycle of stimulus, push the expectation, clock, record outputs 1ns later.
    task automatic drive(input logic rst_v, input logic en_v, input logic [2:0] op_v,
                         input logic [7:0] addr_v, input logic cond_v, input snap_t exp);
        snap_t o;
        RST = rst_v; EN = en_v; OP = op_v; ADDR = addr_v; COND = cond_v;
        exp_q.push_back(exp);
        @(posedge CLK);
        #1;
        o.pc = PC_OUT; o.base = BASE_OUT; o.sp = SP_OUT; o.halted = HALTED; o.err = ERR;
        obs_q.push_back(o);
        RST = 1'b1;
    endtask

    task automatic test_reset_next_stall();
        snap_t e, o;
        int n = 0;
        drive(0, 1, OP_JMP, 8'h55, 1, mk(8'h00, 8'h00, 0, 0, 0)); // reset beats EN/OP
        drive(1, 1, OP_NEXT, 8'h00, 0, mk(8'h01, 8'h00, 0, 0, 0));
        drive(1, 1, OP_NEXT, 8'h00, 0, mk(8'h02, 8'h00, 0, 0, 0));
        drive(1, 1, OP_NEXT, 8'h00, 0, mk(8'h03, 8'h00, 0, 0, 0));
        drive(1, 0, OP_JMP,  8'h99, 0, mk(8'h03, 8'h00, 0, 0, 0));
        drive(1, 0, OP_LDB,  8'h77, 0, mk(8'h03, 8'h00, 0, 0, 0));
        drive(1, 0, OP_CALL, 8'h44, 0, mk(8'h03, 8'h00, 0, 0, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_next_stall[%0d]: got pc=%h base=%h sp=%0d h=%b e=%b, want pc=%h base=%h sp=%0d h=%b e=%b",
                         n, o.pc, o.base, o.sp, o.halted, o.err, e.pc, e.base, e.sp, e.halted, e.err);
            end
            n++;
        end
    endtask

    task automatic test_wrap_jrel_jcond();
        snap_t e, o;
        int n = 0;
        drive(1, 1, OP_JMP,   8'hFF, 0, mk(8'hFF, 8'h00, 0, 0, 0));
        drive(1, 1, OP_NEXT,  8'h00, 0, mk(8'h00, 8'h00, 0, 0, 0));
        drive(1, 1, OP_LDB,   8'hF0, 0, mk(8'h01, 8'hF0, 0, 0, 0));
        drive(1, 1, OP_JREL,  8'h20, 0, mk(8'h10, 8'hF0, 0, 0, 0)); // carry dropped
        drive(1, 1, OP_JCOND, 8'h40, 0, mk(8'h11, 8'hF0, 0, 0, 0));
        drive(1, 1, OP_JCOND, 8'h40, 1, mk(8'h40, 8'hF0, 0, 0, 0));
        drive(1, 1, OP_NEXT,  8'h90, 1, mk(8'h41, 8'hF0, 0, 0, 0)); // COND ignored
        drive(1, 1, OP_JMP,   8'h22, 0, mk(8'h22, 8'hF0, 0, 0, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL wrap_jrel_jcond[%0d]: got pc=%h base=%h sp=%0d h=%b e=%b, want pc=%h base=%h sp=%0d h=%b e=%b",
                         n, o.pc, o.base, o.sp, o.halted, o.err, e.pc, e.base, e.sp, e.halted, e.err);
            end
            n++;
        end
    endtask

    task automatic test_call_ret();
        snap_t e, o;
        int n = 0;
        drive(1, 1, OP_JMP,  8'h10, 0, mk(8'h10, 8'hF0, 0, 0, 0));
        drive(1, 1, OP_CALL, 8'h50, 0, mk(8'h50, 8'hF0, 1, 0, 0));
        drive(1, 1, OP_CALL, 8'h60, 0, mk(8'h60, 8'hF0, 2, 0, 0));
        drive(1, 1, OP_RET,  8'h00, 0, mk(8'h51, 8'hF0, 1, 0, 0));
        drive(1, 1, OP_RET,  8'h00, 0, mk(8'h11, 8'hF0, 0, 0, 0));
        drive(1, 1, OP_JMP,  8'hFF, 0, mk(8'hFF, 8'hF0, 0, 0, 0));
        drive(1, 1, OP_CALL, 8'h30, 0, mk(8'h30, 8'hF0, 1, 0, 0)); // pushes wrapped 0
        drive(1, 0, OP_RET,  8'h00, 0, mk(8'h30, 8'hF0, 1, 0, 0)); // stall holds SP
        drive(1, 1, OP_RET,  8'h00, 0, mk(8'h00, 8'hF0, 0, 0, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL call_ret[%0d]: got pc=%h base=%h sp=%0d h=%b e=%b, want pc=%h base=%h sp=%0d h=%b e=%b",
                         n, o.pc, o.base, o.sp, o.halted, o.err, e.pc, e.base, e.sp, e.halted, e.err);
            end
            n++;
        end
    endtask

    task automatic test_overflow_underflow();
        snap_t e, o;
        int n = 0;
        drive(0, 0, OP_NEXT, 8'h00, 0, mk(8'h00, 8'h00, 0, 0, 0));
        drive(1, 1, OP_CALL, 8'h10, 0, mk(8'h10, 8'h00, 1, 0, 0));
        drive(1, 1, OP_CALL, 8'h20, 0, mk(8'h20, 8'h00, 2, 0, 0));
        drive(1, 1, OP_CALL, 8'h30, 0, mk(8'h30, 8'h00, 3, 0, 0));
        drive(1, 1, OP_CALL, 8'h40, 0, mk(8'h40, 8'h00, 4, 0, 0));
        drive(1, 1, OP_CALL, 8'h50, 0, mk(8'h40, 8'h00, 4, 0, 1)); // overflow
        drive(1, 1, OP_RET,  8'h00, 0, mk(8'h40, 8'h00, 4, 0, 1));
        drive(1, 1, OP_LDB,  8'h33, 0, mk(8'h40, 8'h00, 4, 0, 1));
        drive(0, 1, OP_NEXT, 8'h00, 0, mk(8'h00, 8'h00, 0, 0, 0));
        drive(1, 1, OP_NEXT, 8'h00, 0, mk(8'h01, 8'h00, 0, 0, 0));
        drive(1, 1, OP_RET,  8'h00, 0, mk(8'h01, 8'h00, 0, 0, 1)); // underflow
        drive(1, 1, OP_NEXT, 8'h00, 0, mk(8'h01, 8'h00, 0, 0, 1));
        drive(0, 1, OP_NEXT, 8'h00, 0, mk(8'h00, 8'h00, 0, 0, 0));
        drive(1, 1, OP_NEXT, 8'h00, 0, mk(8'h01, 8'h00, 0, 0, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL overflow_underflow[%0d]: got pc=%h base=%h sp=%0d h=%b e=%b, want pc=%h base=%h sp=%0d h=%b e=%b",
                         n, o.pc, o.base, o.sp, o.halted, o.err, e.pc, e.base, e.sp, e.halted, e.err);
            end
            n++;
        end
    endtask

    task automatic test_halt();
        snap_t e, o;
        int n = 0;
        drive(0, 0, OP_NEXT, 8'h00, 0, mk(8'h00, 8'h00, 0, 0, 0));
        drive(1, 1, OP_JMP,  8'h07, 0, mk(8'h07, 8'h00, 0, 0, 0));
        drive(1, 1, OP_HALT, 8'h00, 0, mk(8'h07, 8'h00, 0, 1, 0));
        for (int i = 0; i < 10; i++) begin
            drive(1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                  mk(8'h07, 8'h00, 0, 1, 0));
        end
        drive(0, 1, OP_JMP,  8'h80, 0, mk(8'h00, 8'h00, 0, 0, 0));
        drive(1, 1, OP_NEXT, 8'h00, 0, mk(8'h01, 8'h00, 0, 0, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL halt[%0d]: got pc=%h base=%h sp=%0d h=%b e=%b, want pc=%h base=%h sp=%0d h=%b e=%b",
                         n, o.pc, o.base, o.sp, o.halted, o.err, e.pc, e.base, e.sp, e.halted, e.err);
            end
            n++;
        end
    endtask

    initial begin
        @(posedge CLK);
        #1;
        test_reset_next_stall();
        test_wrap_jrel_jcond();
        test_call_ret();
        test_overflow_underflow();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
